// File: rtl/matrix_gen_write_ctrl.sv
// matrix_gen_write_ctrl
// Debounces a push button and, on each accepted press, runs a batch of
// generate-then-store transactions: pulse gen_req, wait for gen_done (with a
// timeout), then strobe wr_en into the next ring-buffer slot.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   btn_n             raw asynchronous button, low = pressed
//   sw_row, sw_col    requested matrix dimensions
//   sw_batch          matrices per press (0 behaves as 1)
//   gen_req           one-cycle generator start pulse
//   gen_done          generator result valid pulse
//   wr_en             one-cycle storage write strobe
//   wr_idx            slot being written
//   wr_row, wr_col    dimensions latched at the accepted press
//   busy              controller not idle
//   err_dim           one-cycle pulse when dimensions are rejected
//   err_timeout       sticky flag: generator did not answer in time
//   next_idx          next slot to be written
module matrix_gen_write_ctrl #(
  parameter int MATRIX_NUM   = 8,
  parameter int IDX_W        = 4,
  parameter int MAX_SIZE     = 5,
  parameter int DEBOUNCE_CNT = 100000,
  parameter int CNT_W        = 20,
  parameter int GEN_TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  input  logic [2:0]       sw_row,
  input  logic [2:0]       sw_col,
  input  logic [2:0]       sw_batch,
  output logic             gen_req,
  input  logic             gen_done,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output logic [2:0]       wr_row,
  output logic [2:0]       wr_col,
  output logic             busy,
  output logic             err_dim,
  output logic             err_timeout,
  output logic [IDX_W-1:0] next_idx
);

  localparam int TO_W = $clog2(GEN_TIMEOUT + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] REQ      = 3'd2;
  localparam logic [2:0] WAIT_GEN = 3'd3;
  localparam logic [2:0] WRITE    = 3'd4;
  localparam logic [2:0] NEXT     = 3'd5;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(GEN_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MATRIX_NUM - 1);
  localparam logic [2:0]       MAX_DIM  = 3'(MAX_SIZE);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] db_cnt;
  logic             press;

  logic [2:0]       state;
  logic [2:0]       remaining;
  logic [TO_W-1:0]  to_cnt;
  logic             dim_bad;

  // Reset to 1 so that a released button never looks like a press after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // The stable value only follows the synchronized input once it has differed
  // for DEBOUNCE_CNT consecutive cycles; any bounce back clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= 1'b1;
      stable_d <= 1'b1;
      db_cnt   <= '0;
    end else begin
      stable_d <= stable;
      if (sync2 == stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        stable <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Only the stable 1->0 edge is a press; the release edge is ignored.
  assign press = stable_d & ~stable;

  assign dim_bad = (wr_row == 3'd0) || (wr_row > MAX_DIM) ||
                   (wr_col == 3'd0) || (wr_col > MAX_DIM);

  assign gen_req = (state == REQ);
  assign wr_en   = (state == WRITE);
  assign busy    = (state != IDLE);
  assign err_dim = (state == CHECK) && dim_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_row      <= '0;
      wr_col      <= '0;
      wr_idx      <= '0;
      next_idx    <= '0;
      remaining   <= '0;
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Presses arriving in any other state are simply dropped.
          if (press) begin
            wr_row    <= sw_row;
            wr_col    <= sw_col;
            remaining <= (sw_batch == 3'd0) ? 3'd1 : sw_batch;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (dim_bad) begin
            state <= IDLE;
          end else begin
            err_timeout <= 1'b0;
            state       <= REQ;
          end
        end
        REQ: begin
          to_cnt <= '0;
          state  <= WAIT_GEN;
        end
        WAIT_GEN: begin
          // gen_done wins over a timeout expiring in the same cycle.
          if (gen_done) begin
            wr_idx <= next_idx;
            state  <= WRITE;
          end else if (to_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WRITE: begin
          next_idx <= (next_idx == IDX_LAST) ? '0 : next_idx + 1'b1;
          state    <= NEXT;
        end
        NEXT: begin
          remaining <= remaining - 1'b1;
          state     <= (remaining == 3'd1) ? IDLE : REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_gen_write_ctrl.sv
// tb_matrix_gen_write_ctrl
// Self-checking bench: a behavioural generator answers gen_req, a monitor
// compares every wr_en against a queue of expected writes filled when each
// press is issued, and per-scenario tasks check counts, flags and latencies.
module tb_matrix_gen_write_ctrl;

  localparam int DEB  = 50;
  localparam int GTO  = 16;
  localparam int MNUM = 8;
  localparam int IW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_n = 1'b1;
  logic [2:0]    sw_row = 3'd0;
  logic [2:0]    sw_col = 3'd0;
  logic [2:0]    sw_batch = 3'd0;
  logic          gen_done = 1'b0;
  logic          gen_req;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [2:0]    wr_row;
  logic [2:0]    wr_col;
  logic          busy;
  logic          err_dim;
  logic          err_timeout;
  logic [IW-1:0] next_idx;

  always #5 clk = ~clk;

  matrix_gen_write_ctrl #(
    .MATRIX_NUM(MNUM), .IDX_W(IW), .MAX_SIZE(5),
    .DEBOUNCE_CNT(DEB), .CNT_W(20), .GEN_TIMEOUT(GTO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_n(btn_n),
    .sw_row(sw_row), .sw_col(sw_col), .sw_batch(sw_batch),
    .gen_req(gen_req), .gen_done(gen_done),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_row(wr_row), .wr_col(wr_col),
    .busy(busy), .err_dim(err_dim), .err_timeout(err_timeout),
    .next_idx(next_idx)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [2:0]    row;
    logic [2:0]    col;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  gen_req_cnt = 0;
  int  err_dim_cnt = 0;
  int  wr_cnt = 0;
  int  exp_next = 0;
  int  gen_delay = 5;
  bit  gen_enable = 1'b1;

  // Generator model: gen_done arrives gen_delay cycles after the gen_req cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (gen_req && gen_enable) begin
        repeat (gen_delay) @(negedge clk);
        gen_done = 1'b1;
        @(negedge clk);
        gen_done = 1'b0;
      end
    end
  end

  // Scoreboard consumer: each write must match the oldest expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst_n) begin
      if (gen_req) gen_req_cnt++;
      if (err_dim) err_dim_cnt++;
      if (wr_en) begin
        wr_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got idx=%0d row=%0d col=%0d, required no write",
                   wr_idx, wr_row, wr_col);
        end else begin
          e = exp_q.pop_front();
          if (wr_idx !== e.idx || wr_row !== e.row || wr_col !== e.col) begin
            errors++;
            $display("[TB] FAIL write_data: got idx=%0d row=%0d col=%0d, required idx=%0d row=%0d col=%0d",
                     wr_idx, wr_row, wr_col, e.idx, e.row, e.col);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic expect_batch(input logic [2:0] row, input logic [2:0] col, input int batch);
    wr_t e;
    int n;
    n = (batch == 0) ? 1 : batch;
    for (int i = 0; i < n; i++) begin
      e.idx = IW'(exp_next);
      e.row = row;
      e.col = col;
      exp_q.push_back(e);
      exp_next = (exp_next + 1) % MNUM;
    end
  endtask

  // Drives a clean falling edge, returns the number of edges from the first
  // sampling edge until busy is seen, then releases the button.
  task automatic press(output int lat);
    @(negedge clk);
    btn_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= DEB + 20; i++) begin
      @(posedge clk);
      #1;
      if (busy) begin
        lat = i - 1;
        break;
      end
    end
    btn_n = 1'b1;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL press_busy: busy never rose, required rise within %0d edges", DEB + 20);
    end
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (ok == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle: busy still 1 after 600 cycles, required 0");
    end
    repeat (DEB + 10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gen_req, wr_en, busy, err_dim, err_timeout} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 00000",
               {gen_req, wr_en, busy, err_dim, err_timeout});
    end
    checks++;
    if ({wr_idx, next_idx, wr_row, wr_col} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got wr_idx=%0d next_idx=%0d row=%0d col=%0d, required all 0",
               wr_idx, next_idx, wr_row, wr_col);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int lat, g0, w0;
    g0 = gen_req_cnt;
    w0 = wr_cnt;
    sw_row = 3'd2; sw_col = 3'd3; sw_batch = 3'd1;
    expect_batch(3'd2, 3'd3, 1);
    press(lat);
    sw_row = 3'd7; sw_col = 3'd7;
    checks++;
    if (lat !== DEB + 2) begin
      errors++;
      $display("[TB] FAIL press_latency: got %0d edges, required %0d", lat, DEB + 2);
    end
    wait_idle();
    checks++;
    if (gen_req_cnt - g0 !== 1 || wr_cnt - w0 !== 1) begin
      errors++;
      $display("[TB] FAIL clean_counts: got gen_req=%0d wr_en=%0d, required 1 and 1",
               gen_req_cnt - g0, wr_cnt - w0);
    end
    checks++;
    if (next_idx !== 4'd1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clean_after: got next_idx=%0d busy=%b, required 1 and 0", next_idx, busy);
    end
    checks++;
    if (wr_row !== 3'd2 || wr_col !== 3'd3) begin
      errors++;
      $display("[TB] FAIL latched_dims: got row=%0d col=%0d, required 2 and 3", wr_row, wr_col);
    end
  endtask

  task automatic test_bounce();
    int lat, g0;
    bit early;
    g0 = gen_req_cnt;
    early = 1'b0;
    sw_row = 3'd3; sw_col = 3'd3; sw_batch = 3'd1;
    expect_batch(3'd3, 3'd3, 1);
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      btn_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (10) begin
        @(negedge clk);
        if (busy) early = 1'b1;
      end
    end
    press(lat);
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bounce_early: got busy during bounce, required none");
    end
    checks++;
    if (lat !== DEB + 2) begin
      errors++;
      $display("[TB] FAIL bounce_latency: got %0d edges, required %0d", lat, DEB + 2);
    end
    wait_idle();
    checks++;
    if (gen_req_cnt - g0 !== 1) begin
      errors++;
      $display("[TB] FAIL bounce_events: got %0d gen_req, required 1", gen_req_cnt - g0);
    end
  endtask

  task automatic test_batch_wrap();
    int lat, g0, w0;
    sw_row = 3'd5; sw_col = 3'd5; sw_batch = 3'd4;
    expect_batch(3'd5, 3'd5, 4);
    press(lat);
    wait_idle();
    checks++;
    if (next_idx !== 4'd6) begin
      errors++;
      $display("[TB] FAIL batch4_next: got %0d, required 6", next_idx);
    end
    g0 = gen_req_cnt;
    w0 = wr_cnt;
    sw_batch = 3'd3;
    expect_batch(3'd5, 3'd5, 3);
    press(lat);
    wait_idle();
    checks++;
    if (next_idx !== 4'd1) begin
      errors++;
      $display("[TB] FAIL wrap_next: got %0d, required 1", next_idx);
    end
    checks++;
    if (gen_req_cnt - g0 !== 3 || wr_cnt - w0 !== 3) begin
      errors++;
      $display("[TB] FAIL wrap_counts: got gen_req=%0d wr_en=%0d, required 3 and 3",
               gen_req_cnt - g0, wr_cnt - w0);
    end
  endtask

  task automatic test_bad_dims();
    int lat, g0, w0, d0;
    logic [2:0] rows[2];
    logic [2:0] cols[2];
    rows[0] = 3'd6; cols[0] = 3'd3;
    rows[1] = 3'd2; cols[1] = 3'd0;
    for (int k = 0; k < 2; k++) begin
      g0 = gen_req_cnt;
      w0 = wr_cnt;
      d0 = err_dim_cnt;
      sw_row = rows[k]; sw_col = cols[k]; sw_batch = 3'd2;
      press(lat);
      wait_idle();
      checks++;
      if (err_dim_cnt - d0 !== 1 || gen_req_cnt - g0 !== 0 || wr_cnt - w0 !== 0) begin
        errors++;
        $display("[TB] FAIL bad_dims_%0d: got err_dim=%0d gen_req=%0d wr_en=%0d, required 1 0 0",
                 k, err_dim_cnt - d0, gen_req_cnt - g0, wr_cnt - w0);
      end
    end
  endtask

  task automatic test_timeout();
    int lat, w0, to;
    bit seen;
    w0 = wr_cnt;
    gen_enable = 1'b0;
    sw_row = 3'd1; sw_col = 3'd1; sw_batch = 3'd2;
    press(lat);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (gen_req) begin
        seen = 1'b1;
        break;
      end
    end
    // gen_req is sampled at the next edge; the flag lands GTO edges after that.
    to = -1;
    for (int j = 1; j <= GTO + 10; j++) begin
      @(posedge clk);
      #1;
      if (err_timeout) begin
        to = j;
        break;
      end
    end
    checks++;
    if (!seen || to !== GTO + 1) begin
      errors++;
      $display("[TB] FAIL timeout_latency: got gen_req_seen=%b edges=%0d, required 1 and %0d",
               seen, to, GTO + 1);
    end
    wait_idle();
    checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0 || wr_cnt - w0 !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_state: got err_timeout=%b busy=%b writes=%0d, required 1 0 0",
               err_timeout, busy, wr_cnt - w0);
    end
    gen_enable = 1'b1;
    w0 = wr_cnt;
    sw_row = 3'd4; sw_col = 3'd4; sw_batch = 3'd0;
    expect_batch(3'd4, 3'd4, 0);
    press(lat);
    wait_idle();
    checks++;
    if (err_timeout !== 1'b0 || wr_cnt - w0 !== 1) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got err_timeout=%b writes=%0d, required 0 and 1",
               err_timeout, wr_cnt - w0);
    end
  endtask

  task automatic test_done_at_expiry();
    int lat, w0;
    w0 = wr_cnt;
    gen_delay = GTO;
    sw_row = 3'd1; sw_col = 3'd2; sw_batch = 3'd1;
    expect_batch(3'd1, 3'd2, 1);
    press(lat);
    wait_idle();
    gen_delay = 5;
    checks++;
    if (err_timeout !== 1'b0 || wr_cnt - w0 !== 1) begin
      errors++;
      $display("[TB] FAIL done_vs_timeout: got err_timeout=%b writes=%0d, required 0 and 1",
               err_timeout, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_midbatch();
    int lat, g0, w0;
    bit reached;
    g0 = gen_req_cnt;
    w0 = wr_cnt;
    sw_row = 3'd2; sw_col = 3'd2; sw_batch = 3'd3;
    expect_batch(3'd2, 3'd2, 1);
    press(lat);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gen_req_cnt - g0 == 2) begin
        reached = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (!reached || {gen_req, wr_en, busy, err_dim, err_timeout} !== 5'b0 ||
        {next_idx, wr_row, wr_col} !== '0) begin
      errors++;
      $display("[TB] FAIL midbatch_reset: got reached=%b flags=%b next_idx=%0d row=%0d col=%0d, required 1 00000 0 0 0",
               reached, {gen_req, wr_en, busy, err_dim, err_timeout}, next_idx, wr_row, wr_col);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_next = 0;
    repeat (DEB + 10) @(negedge clk);
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("[TB] FAIL midbatch_writes: got %0d writes, required 1", wr_cnt - w0);
    end
    sw_row = 3'd3; sw_col = 3'd1; sw_batch = 3'd1;
    expect_batch(3'd3, 3'd1, 1);
    press(lat);
    wait_idle();
    checks++;
    if (next_idx !== 4'd1) begin
      errors++;
      $display("[TB] FAIL post_reset_slot: got next_idx=%0d, required 1", next_idx);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_batch_wrap();
    test_bad_dims();
    test_timeout();
    test_done_at_expiry();
    test_reset_midbatch();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL missing_writes: got %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
